de4_qsys_nios2_div_cell: RTL and testbench



---
 rtl/de4_qsys_nios2_div_pkg.sv | 14 +
 rtl/de4_qsys_nios2_div_cell_step.sv | 25 ++
 rtl/de4_qsys_nios2_div_cell.sv | 138 +++++++++++++
 tb/tb_de4_qsys_nios2_div_cell.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/de4_qsys_nios2_div_pkg.sv
// Shared types and constants for the Nios II multi-cycle divide cell.
package de4_qsys_nios2_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_STEPS = 32;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/de4_qsys_nios2_div_cell_step.sv
// Single combinational radix-2 restoring division step.
module de4_qsys_nios2_div_step
  import de4_qsys_nios2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             next_bit,
  output logic [WIDTH:0]   rem_out,
  output logic             quot_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The full shifted value takes part in the trial subtract so its borrow is exact.
  always_comb begin
    shifted  = {rem_in, next_bit};
    diff     = shifted - {2'b00, divisor};
    quot_bit = ~diff[WIDTH+1];
    rem_out  = quot_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/de4_qsys_nios2_div_cell.sv
// Multi-cycle 32-bit restoring divider (div/divu) with busy stall and done pulse.
// Optional macro NIOS2_DIV_EARLY_OUT_EN skips CALC for zero divisor or |dividend| < |divisor|.
module de4_qsys_nios2_div_cell
  import de4_qsys_nios2_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_div_start,
  input  logic             E_div_abort,
  input  logic             E_ctrl_div_signed,
  input  logic [WIDTH-1:0] E_src1_div_cell,
  input  logic [WIDTH-1:0] E_src2_div_cell,
  output logic             A_div_busy,
  output logic             A_div_done,
  output logic [WIDTH-1:0] A_div_quotient,
  output logic [WIDTH-1:0] A_div_remainder
);

  localparam int CNT_W = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  div_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH:0]   rem_r;
  logic [WIDTH-1:0] dividend_orig;
  logic             q_neg;
  logic             r_neg;
  logic             div_zero;

  logic             src1_neg, src2_neg;
  logic [WIDTH-1:0] src1_abs, src2_abs;
  logic             early_out;
  logic [WIDTH:0]   step_rem;
  logic             step_q;

  always_comb begin
    src1_neg = E_ctrl_div_signed & E_src1_div_cell[WIDTH-1];
    src2_neg = E_ctrl_div_signed & E_src2_div_cell[WIDTH-1];
    src1_abs = src1_neg ? -E_src1_div_cell : E_src1_div_cell;
    src2_abs = src2_neg ? -E_src2_div_cell : E_src2_div_cell;
`ifdef NIOS2_DIV_EARLY_OUT_EN
    early_out = (E_src2_div_cell == '0) || (src1_abs < src2_abs);
`else
    early_out = 1'b0;
`endif
  end

  de4_qsys_nios2_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in  (rem_r),
    .divisor (divisor_r),
    .next_bit(dvd_sh[WIDTH-1]),
    .rem_out (step_rem),
    .quot_bit(step_q)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (E_div_start) state_next = early_out ? FIX : CALC;
      CALC: begin
        if (E_div_abort)           state_next = IDLE;
        else if (cnt == LAST_STEP) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      A_div_busy      <= 1'b0;
      A_div_done      <= 1'b0;
      A_div_quotient  <= '0;
      A_div_remainder <= '0;
      cnt             <= '0;
      divisor_r       <= '0;
      dvd_sh          <= '0;
      rem_r           <= '0;
      dividend_orig   <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      div_zero        <= 1'b0;
    end else begin
      state      <= state_next;
      A_div_busy <= (state_next != IDLE);
      A_div_done <= 1'b0;
      case (state)
        IDLE: begin
          if (E_div_start) begin
            divisor_r     <= src2_abs;
            dividend_orig <= E_src1_div_cell;
            q_neg         <= src1_neg ^ src2_neg;
            r_neg         <= src1_neg;
            div_zero      <= (E_src2_div_cell == '0);
            cnt           <= '0;
            // Early-out preloads the finished quotient (0) and remainder (|dividend|).
            if (early_out) begin
              dvd_sh <= '0;
              rem_r  <= {1'b0, src1_abs};
            end else begin
              dvd_sh <= src1_abs;
              rem_r  <= '0;
            end
          end
        end
        CALC: begin
          if (!E_div_abort) begin
            rem_r  <= step_rem;
            dvd_sh <= {dvd_sh[WIDTH-2:0], step_q};
            cnt    <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!E_div_abort) begin
            A_div_done <= 1'b1;
            if (div_zero) begin
              A_div_quotient  <= WIDTH'(DIV_ZERO_QUOTIENT);
              A_div_remainder <= dividend_orig;
            end else begin
              A_div_quotient  <= q_neg ? -dvd_sh : dvd_sh;
              A_div_remainder <= r_neg ? -rem_r[WIDTH-1:0] : rem_r[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_de4_qsys_nios2_div_cell.sv
// Directed bench for de4_qsys_nios2_div_cell with an arithmetic reference model.
module tb_de4_qsys_nios2_div_cell;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] rem;

  int tests = 0;
  int fails = 0;

`ifdef NIOS2_DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 2;
`else
  localparam int EARLY_LAT = 34;
`endif

  de4_qsys_nios2_div_cell #(
    .WIDTH(32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .E_div_start      (start),
    .E_div_abort      (abort),
    .E_ctrl_div_signed(sgn),
    .E_src1_div_cell  (src1),
    .E_src2_div_cell  (src2),
    .A_div_busy       (busy),
    .A_div_done       (done),
    .A_div_quotient   (quot),
    .A_div_remainder  (rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result: {quotient, remainder} from plain arithmetic.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    return {a / b, a % b};
  endfunction

  function automatic logic ref_early(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] aa, bb;
`ifdef NIOS2_DIV_EARLY_OUT_EN
    aa = (s && a[31]) ? -a : a;
    bb = (s && b[31]) ? -b : b;
    return (b == 32'd0) || (aa < bb);
`else
    aa = a;
    bb = b;
    return 1'b0 && (aa == bb);
`endif
  endfunction

  // Timing model: an accepted start makes busy visible for a fixed span, then done.
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [31:0] m_q = '0, m_r = '0;
  logic [63:0] m_pend = '0;
  int          m_left = 0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_q     <= '0;
      m_r     <= '0;
      m_left  <= 0;
      m_valid <= 1'b1;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (abort) begin
          m_left <= 0;
          m_busy <= 1'b0;
        end else if (m_left == 1) begin
          m_left <= 0;
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= m_pend[63:32];
          m_r    <= m_pend[31:0];
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_pend <= ref_div(src1, src2, sgn);
        m_left <= ref_early(src1, src2, sgn) ? 1 : 33;
        m_busy <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_quot", quot, m_q);
      check("cyc_rem",  rem,  m_r);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(inout int n);
    while (done !== 1'b1 && n < 60) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic ab, input logic [31:0] eq,
                        input logic [31:0] er, input int lat);
    int n;
    step();
    src1 = a; src2 = b; sgn = s; start = 1'b1; abort = ab;
    step();
    start = 1'b0; abort = 1'b0; n = 1;
    check({name, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({name, "_lat"}, 32'(n), 32'(lat));
    check({name, "_q"}, quot, eq);
    check({name, "_r"}, rem, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q", quot, 32'd0);
    check("rst_r", rem, 32'd0);
    reset = 1'b0;

    run_op("u100_7",    32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         32'd2,          34);
    run_op("s_m7_2",    32'hFFFF_FFF9,  32'h0000_0002,  1'b1, 1'b0, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  34);
    run_op("u_m7_2",    32'hFFFF_FFF9,  32'h0000_0002,  1'b0, 1'b0, 32'h7FFF_FFFC,  32'd1,          34);
    run_op("s_7_m2",    32'd7,          32'hFFFF_FFFE,  1'b1, 1'b0, 32'hFFFF_FFFD,  32'd1,          34);
    run_op("s_m100_m7", 32'hFFFF_FF9C,  32'hFFFF_FFF9,  1'b1, 1'b0, 32'd14,         32'hFFFF_FFFE,  34);
    run_op("u_div0",    32'h1234_5678,  32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  EARLY_LAT);
    run_op("s_div0",    32'h8000_0005,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF,  32'h8000_0005,  EARLY_LAT);
    run_op("s_ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000,  32'd0,          34);
    run_op("u_min_1",   32'h8000_0000,  32'd1,          1'b0, 1'b0, 32'h8000_0000,  32'd0,          34);
    run_op("u_5_9",     32'd5,          32'd9,          1'b0, 1'b0, 32'd0,          32'd5,          EARLY_LAT);
    run_op("s_m5_9",    32'hFFFF_FFFB,  32'd9,          1'b1, 1'b0, 32'd0,          32'hFFFF_FFFB,  EARLY_LAT);
    run_op("st_ab",     32'd45,         32'd6,          1'b0, 1'b1, 32'd7,          32'd3,          34);

    // Second start mid-operation must be ignored.
    step();
    src1 = 32'd1000; src2 = 32'd3; sgn = 1'b0; start = 1'b1;
    step();
    start = 1'b0; n = 1;
    repeat (4) begin step(); n++; end
    src1 = 32'd77; src2 = 32'd5; sgn = 1'b1; start = 1'b1;
    step();
    start = 1'b0; n++;
    wait_done(n);
    check("ign_lat", 32'(n), 32'd34);
    check("ign_q", quot, 32'd333);
    check("ign_r", rem, 32'd1);

    // Abort while idle changes nothing.
    abort = 1'b1;
    repeat (3) step();
    abort = 1'b0;
    check("idle_ab_busy", 32'(busy), 32'd0);
    check("idle_ab_q", quot, 32'd333);

    // Abort in CALC: busy drops next cycle, results held, no done.
    src1 = 32'hFFFF_FFF0; src2 = 32'd3; sgn = 1'b0; start = 1'b1;
    step();
    start = 1'b0; n = 1;
    repeat (9) begin step(); n++; end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("ab_busy", 32'(busy), 32'd0);
    check("ab_q", quot, 32'd333);
    check("ab_r", rem, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (done === 1'b1) seen = 1'b1;
    end
    check("ab_nodone", 32'(seen), 32'd0);

    // Reset mid-operation clears every output.
    src1 = 32'd50; src2 = 32'd7; sgn = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    step();
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_done", 32'(done), 32'd0);
    check("mr_q", quot, 32'd0);
    check("mr_r", rem, 32'd0);
    reset = 1'b0;

    run_op("post_rst", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 34);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
